// File: rtl/ledr_pkg.sv
// ledr_pkg: LED patterns shared by ledr_driver and ledr_sequencer, plus the
// sequencer state type.
//   LEDR_0..LEDR_10 : binary counter phase (LEDR_n == n)
//   LEDR_1A..LEDR_ON: effect phase, 1A -> 1B -> 2A -> 2B -> 2C -> ON
//   seq_state_t     : sequencer FSM states
package ledr_pkg;

    localparam logic [9:0] LEDR_0  = 10'd0;
    localparam logic [9:0] LEDR_1  = 10'd1;
    localparam logic [9:0] LEDR_2  = 10'd2;
    localparam logic [9:0] LEDR_3  = 10'd3;
    localparam logic [9:0] LEDR_4  = 10'd4;
    localparam logic [9:0] LEDR_5  = 10'd5;
    localparam logic [9:0] LEDR_6  = 10'd6;
    localparam logic [9:0] LEDR_7  = 10'd7;
    localparam logic [9:0] LEDR_8  = 10'd8;
    localparam logic [9:0] LEDR_9  = 10'd9;
    localparam logic [9:0] LEDR_10 = 10'd10;

    localparam logic [9:0] LEDR_1A = 10'b1010101010;
    localparam logic [9:0] LEDR_1B = 10'b0101010101;
    localparam logic [9:0] LEDR_2A = 10'b1111100000;
    localparam logic [9:0] LEDR_2B = 10'b0000011111;
    localparam logic [9:0] LEDR_2C = 10'b1100110011;
    localparam logic [9:0] LEDR_ON = 10'b1111111111;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        CLEAR,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: programmable step-period counter.
//   clk, reset : clock, asynchronous active-low reset
//   run        : count enable (counter frozen when low)
//   clr        : synchronous clear, wins over run
//   period     : step period P in clk cycles (P >= 2)
//   tick       : high while running on the terminal count; counter wraps to 0
// The compare is ">=" so a period shrunk below the current count terminates
// on the next cycle instead of running the counter off the end.
module tick_divider #(
    parameter  int TICK_DIV = 25_000_000,
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
    localparam int PW       = $clog2(TICK_DIV + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          clr,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [CW-1:0] cnt;
    logic [PW-1:0] cnt_p1;

    assign cnt_p1 = PW'(cnt) + PW'(1);
    assign tick   = run && (cnt_p1 >= period);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/ledr_sequencer.sv
// ledr_sequencer: run/pause/step controller for ledr_driver.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : IDLE/PAUSE -> RUN, DONE -> CLEAR
//   stop        : RUN -> PAUSE
//   step        : one driver step while paused
//   speed       : period select, P = max(2, TICK_DIV >> speed)
//   drv_out     : current driver output (looped back to drv_in)
//   drv_reset   : synchronous reset to the driver
//   drv_en      : one-cycle step strobe to the driver
//   drv_in      : pattern presented to the driver
//   busy, done  : in RUN / in DONE
//   loop_cnt    : completed effect loops
// All outputs are registered.
module ledr_sequencer
    import ledr_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int LOOPS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] speed,
    input  logic [9:0] drv_out,
    output logic       drv_reset,
    output logic       drv_en,
    output logic [9:0] drv_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] loop_cnt
);

    localparam int PW = $clog2(TICK_DIV + 1);

    seq_state_t    state;
    logic [PW-1:0] period;
    logic          tick;
    logic          run_div;
    logic          clr_div;
    logic          loop_hit;
    logic          last_loop;

    // Floor of 2 keeps drv_in current at every strobe (one cycle for the
    // driver to update, one for the feedback register).
    always_comb begin
        period = PW'(TICK_DIV >> speed);
        if (period < PW'(2))
            period = PW'(2);
    end

    // Divider is frozen in PAUSE so a resume keeps its phase.
    assign run_div = (state == RUN);
    assign clr_div = (state == IDLE) || (state == CLEAR) || (state == DONE);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .run    (run_div),
        .clr    (clr_div),
        .period (period),
        .tick   (tick)
    );

    // A strobe on 2C is the step into ON, which closes one effect loop.
    // The counter phase never shows 2C so it never counts.
    assign loop_hit  = drv_en && (drv_in == LEDR_2C);
    assign last_loop = loop_hit && (loop_cnt == 4'(LOOPS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drv_reset <= 1'b1;
            drv_en    <= 1'b0;
            drv_in    <= LEDR_0;
            busy      <= 1'b0;
            done      <= 1'b0;
            loop_cnt  <= '0;
        end else begin
            drv_in <= drv_out;
            drv_en <= 1'b0;
            if (loop_hit)
                loop_cnt <= loop_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        drv_reset <= 1'b0;
                        busy      <= 1'b1;
                        loop_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (last_loop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // A stop on the terminal count still gets its strobe.
                        drv_en <= tick;
                        if (stop) begin
                            state <= PAUSE;
                            busy  <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (last_loop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        drv_en <= step;
                    end
                end
                CLEAR: begin
                    state     <= RUN;
                    drv_reset <= 1'b0;
                    busy      <= 1'b1;
                    loop_cnt  <= '0;
                end
                DONE: begin
                    if (start) begin
                        state     <= CLEAR;
                        drv_reset <= 1'b1;
                        done      <= 1'b0;
                        loop_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    drv_reset <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ledr_sequencer.sv
// tb_ledr_sequencer: closed-loop bench, sequencer plus a behavioural
// ledr_driver. Expected behaviour comes from a strobe-count model: the
// number of completed strobes fixes the pattern, the loop count and DONE.
module tb_ledr_sequencer;
    import ledr_pkg::*;

    localparam int TD      = 4;
    localparam int NL      = 2;
    localparam int NSTROBE = 10 + 6 * NL;

    localparam logic [9:0] WALK [17] = '{
        LEDR_0, LEDR_1, LEDR_2, LEDR_3, LEDR_4, LEDR_5, LEDR_6, LEDR_7,
        LEDR_8, LEDR_9, LEDR_10, LEDR_1A, LEDR_1B, LEDR_2A, LEDR_2B,
        LEDR_2C, LEDR_ON};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [9:0] drv_out;
    logic       drv_reset, drv_en, busy, done;
    logic [9:0] drv_in;
    logic [3:0] loop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ledr_sequencer #(.TICK_DIV(TD), .LOOPS(NL)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .speed(speed), .drv_out(drv_out), .drv_reset(drv_reset),
        .drv_en(drv_en), .drv_in(drv_in), .busy(busy), .done(done),
        .loop_cnt(loop_cnt));

    // Pattern after n strobes: 0..10 counter, then the effect loop repeats.
    function automatic logic [9:0] pat(input int n);
        if (n <= 10) return WALK[n];
        return WALK[11 + (n - 11) % 6];
    endfunction

    function automatic logic [9:0] drv_next(input logic [9:0] p);
        for (int i = 0; i < 17; i++)
            if (WALK[i] == p) return (i == 16) ? WALK[11] : WALK[i + 1];
        return LEDR_0;
    endfunction

    // Behavioural ledr_driver.
    always @(posedge clk) begin
        if (drv_reset)   drv_out <= LEDR_0;
        else if (drv_en) drv_out <= drv_next(drv_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. mode: 0 idle, 1 run, 2 pause, 3 clear, 4 done.
    int         m_mode, m_phase, m_n, m_en;
    logic [9:0] m_out, m_in;

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_n = 0; m_en = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit stp, input logic [1:0] spd);
        int p, en;
        bit fin;
        p = TD >> spd;
        if (p < 2) p = 2;
        fin = (m_en != 0) && (m_n + 1 == NSTROBE);
        en = 0;
        m_in = m_out;
        if (m_en != 0) m_n++;
        case (m_mode)
            0: if (st) begin m_mode = 1; m_phase = 0; end
            1: if (fin) m_mode = 4;
               else begin
                   if (m_phase >= p - 1) begin en = 1; m_phase = 0; end
                   else m_phase++;
                   if (sp) m_mode = 2;
               end
            2: if (fin) m_mode = 4;
               else if (st) m_mode = 1;
               else if (stp) en = 1;
            3: begin m_mode = 1; m_phase = 0; m_n = 0; end
            default: if (st) m_mode = 3;
        endcase
        m_en = en;
        m_out = pat(m_n);
    endtask

    task automatic compare_all();
        int lc;
        lc = (m_mode == 3 || m_n < 10) ? 0 : (m_n - 10) / 6;
        chk("drv_en", 32'(drv_en), 32'(m_en));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 4));
        chk("drv_reset", 32'(drv_reset), 32'(m_mode == 0 || m_mode == 3));
        chk("loop_cnt", 32'(loop_cnt), 32'(lc));
        chk("drv_out", 32'(drv_out), 32'(m_out));
        chk("drv_in", 32'(drv_in), 32'(m_in));
    endtask

    // One clock: apply inputs, predict, advance, compare.
    task automatic cyc(input bit st, input bit sp, input bit stp);
        start = st; stop = sp; step = stp;
        model_step(st, sp, stp, speed);
        @(posedge clk); #1;
        start = 0; stop = 0; step = 0;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_drv_reset", 32'(drv_reset), 32'd1);
        chk("rst_drv_en", 32'(drv_en), 32'd0);
        chk("rst_drv_in", 32'(drv_in), 32'(LEDR_0));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_loop_cnt", 32'(loop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        m_out = LEDR_0;
    endtask

    typedef struct {
        logic [1:0] spd;
        int         gap;
        int         done_at;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [4];
        int   n, first, second, dn, c;

        tbl[0] = '{2'd0, 4, 89};
        tbl[1] = '{2'd1, 2, 45};
        tbl[2] = '{2'd2, 2, 45};
        tbl[3] = '{2'd3, 2, 45};

        #2;
        // Idle after reset: no strobes, driver parked at LEDR_0.
        do_reset();
        n = 0;
        repeat (20) begin cyc(0, 0, 0); n += int'(drv_en); end
        chk("idle_no_strobe", 32'(n), 32'd0);
        chk("idle_drv_out", 32'(drv_out), 32'(LEDR_0));

        // Full runs at each speed: cadence and completion time.
        for (int i = 0; i < 4; i++) begin
            speed = tbl[i].spd;
            do_reset();
            cyc(1, 0, 0);
            first = -1; second = -1; dn = -1;
            for (int k = 1; k <= 200 && dn < 0; k++) begin
                cyc(0, 0, 0);
                if (drv_en) begin
                    if (first < 0) first = k;
                    else if (second < 0) second = k;
                end
                if (done) dn = k;
            end
            chk("first_strobe", 32'(first), 32'(tbl[i].gap));
            chk("strobe_gap", 32'(second - first), 32'(tbl[i].gap));
            chk("done_cycle", 32'(dn), 32'(tbl[i].done_at));
            repeat (5) cyc(0, 0, 0);
            chk("final_loops", 32'(loop_cnt), 32'(NL));
            chk("final_on", 32'(drv_out), 32'(LEDR_ON));
        end

        // Pause after LEDR_5, single steps, resume with held phase.
        speed = 2'd0;
        do_reset();
        cyc(1, 0, 0);
        for (int k = 0; k < 100 && drv_out !== LEDR_5; k++) cyc(0, 0, 0);
        chk("reach_5", 32'(drv_out), 32'(LEDR_5));
        cyc(0, 1, 0);
        n = 0;
        repeat (30) begin cyc(0, 0, 0); n += int'(drv_en); end
        chk("pause_quiet", 32'(n), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1);
            chk("step_en", 32'(drv_en), 32'd1);
            cyc(0, 0, 0);
            chk("step_out", 32'(drv_out), 32'(WALK[6 + k]));
            cyc(0, 0, 0);
        end
        cyc(1, 0, 0);
        chk("resume_busy", 32'(busy), 32'd1);
        c = -1;
        for (int k = 1; k <= 10 && c < 0; k++) begin
            cyc(0, 0, 0);
            if (drv_en) c = k;
        end
        chk("resume_phase", 32'(c), 32'd2);

        // Finish, then restart from DONE through CLEAR.
        for (int k = 0; k < 200 && !done; k++) cyc(0, 0, 0);
        chk("pause_run_done", 32'(done), 32'd1);
        cyc(1, 0, 0);
        chk("clear_drv_reset", 32'(drv_reset), 32'd1);
        chk("clear_loop_cnt", 32'(loop_cnt), 32'd0);
        c = -1;
        for (int k = 1; k <= 10 && c < 0; k++) begin
            cyc(0, 0, 0);
            if (k == 1) chk("clear_drv_out", 32'(drv_out), 32'(LEDR_0));
            if (drv_en) c = k;
        end
        chk("restart_strobe", 32'(c), 32'd5);

        // start and stop together in RUN: stop wins.
        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        chk("start_stop_busy", 32'(busy), 32'd0);
        n = 0;
        repeat (10) begin cyc(0, 0, 0); n += int'(drv_en); end
        chk("start_stop_quiet", 32'(n), 32'd0);

        // Asynchronous reset in the effect phase.
        do_reset();
        speed = 2'd1;
        cyc(1, 0, 0);
        for (int k = 0; k < 100 && drv_out !== LEDR_1B; k++) cyc(0, 0, 0);
        chk("reach_1b", 32'(drv_out), 32'(LEDR_1B));
        #1 reset = 1'b0;
        #1;
        chk("async_drv_reset", 32'(drv_reset), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_drv_in", 32'(drv_in), 32'(LEDR_0));
        chk("async_loop_cnt", 32'(loop_cnt), 32'd0);
        model_reset();
        #1 reset = 1'b1;
        cyc(0, 0, 0);
        chk("post_reset_out", 32'(drv_out), 32'(LEDR_0));

        // Random start/stop/step/speed against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            bit st, sp, stp;
            st  = ($urandom % 10) == 0;
            sp  = ($urandom % 10) == 0;
            stp = (($urandom % 4) == 0) && (m_en == 0);
            if (($urandom % 40) == 0) speed = 2'($urandom);
            cyc(st, sp, stp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ledr_sequencer.md
# ledr_sequencer

Controller that sequences `ledr_driver` on the DE1-SoC. It generates the driver's one-cycle enable strobes from a programmable clock divider and feeds the driver's output back to its input. It supports run, pause and single-step. It counts completed effect loops and parks the LEDs at all-on after a programmed number of loops.

## Interface
Parameters:
- `TICK_DIV`, 25_000_000: base step period in clk cycles (2 Hz at 50 MHz).
- `LOOPS`, 2: effect loops (1A→ON) to run before DONE; range 1..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request.
  - IDLE/PAUSE → RUN.
  - DONE → CLEAR.
- `stop` in 1: single-cycle request; RUN → PAUSE.
- `step` in 1: single-cycle request; in PAUSE, issue exactly one driver step.
- `speed` in 2: period select; P = max(2, TICK_DIV >> speed).
- `drv_out` in 10: current `ledr_driver` output.
- `drv_reset` out 1: active-high synchronous reset to `ledr_driver`.
- `drv_en` out 1: one-cycle step strobe to `ledr_driver`.
- `drv_in` out 10: pattern fed to `ledr_driver.in`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `loop_cnt` out 4: completed effect loops.

## Operation
All outputs are registered.

Reset values:
- `drv_reset`=1, `drv_en`=0, `drv_in`=`LEDR_0`.
- `busy`=0, `done`=0, `loop_cnt`=0.
- Divider=0, state=IDLE.

States:
- **IDLE**
  - `drv_reset`=1.
  - `start` → RUN: clear divider and `loop_cnt`; deassert `drv_reset`.
- **RUN**
  - Divider counts 0..P-1.
  - When the divider is at P-1: pulse `drv_en` for 1 cycle and wrap the divider to 0.
  - `stop` → PAUSE; divider holds its value.
- **PAUSE**
  - Divider frozen; `drv_en`=0, except that `step` gives one `drv_en` pulse.
  - `start` → RUN; divider resumes from its held value, not cleared.
- **CLEAR**
  - One cycle: `drv_reset`=1, divider and `loop_cnt` cleared, then → RUN.
- **DONE**
  - `drv_en`=0; driver holds `LEDR_ON`.
  - `start` → CLEAR.

Feedback and loop counting:
- `drv_in` <= `drv_out` every cycle.
- Loop counting: any `drv_en` pulse issued while `drv_in`==`LEDR_2C` increments `loop_cnt`.
- When the increment reaches `LOOPS`, next state is DONE, from either RUN or PAUSE.
- `LEDR_2C` occurs only in the effect phase, so the 0..10 counter phase never counts.

Simultaneous events:
- `start`&`stop` in RUN: stop wins.
- `start`&`stop` in IDLE/PAUSE/DONE: start wins.
- `stop` in the same cycle as a terminal count: the strobe is still issued; PAUSE starts next cycle.
- `step` outside PAUSE: ignored.
- `stop`, `step` in IDLE/CLEAR/DONE: ignored.
- `speed` change: takes effect at the next divider compare. If divider ≥ new P-1, the next cycle is treated as terminal, then the divider wraps to 0.

Reset mid-operation:
- Asserting `reset` forces every output to its reset value immediately, independent of clk.
- State returns to IDLE.
- The driver is re-zeroed on the first clk edge after release, via `drv_reset`=1.

## Timing
- Enable cadence:
  - Start accepted at edge k.
  - First `drv_en` high in cycle k+P.
  - Subsequent strobes every P cycles.
- `drv_out` changes one cycle after `drv_en`.
- `drv_in` follows `drv_out` one cycle later.
- P ≥ 2 guarantees `drv_in` is current at every strobe.
- A full run is 10 counter steps + 6·LOOPS effect steps = 22 strobes at LOOPS=2.
- `done` rises the cycle after the final strobe.
- `step` → `drv_en` latency: 1 cycle.
- `start` in DONE → first strobe at P+1 cycles (CLEAR adds 1 cycle).

## Structure
- Shared package `ledr_pkg` holds:
  - `LEDR_0`..`LEDR_10`, `LEDR_1A`, `LEDR_1B`, `LEDR_2A`, `LEDR_2B`, `LEDR_2C`, `LEDR_ON` (migrated from defines).
  - `seq_state_t` enum {IDLE, RUN, PAUSE, CLEAR, DONE}.
- Sub-module `tick_divider`:
  - Inputs: `clk`, `reset`, `run`, `clr`, `period`.
  - Output: `tick`.
  - Counter width = $clog2(TICK_DIV).
- The FSM, loop counter and output registers stay in `ledr_sequencer`.
- Bench instantiates `ledr_sequencer` + `ledr_driver` closed-loop.

## Test plan
Common setup: TICK_DIV=4, LOOPS=2, speed=0 (P=4).

1. Reset held low → all outputs at reset values; release, no start for 20 cycles → `drv_en` never asserts, `drv_out`=`LEDR_0`.
2. Start at cycle 0 → strobes at 4, 8, …, 88 (22 total); `drv_out` walks `LEDR_1`..`LEDR_10`, then 1A..ON twice; `loop_cnt`=2; `done`=1 at cycle 89; `drv_out`=`LEDR_ON` holds.
3. Mid-run pause:
   - `stop` after `LEDR_5` → no strobes for 30 cycles.
   - 3 `step` pulses → `LEDR_6`, `LEDR_7`, `LEDR_8`, one cycle after each step.
   - `start` → RUN resumes with the held divider phase.
4. speed=1 (P=2), then speed=3 (clamped P=2) → strobes every 2 cycles; full run completes with `done` at start+45.
5. DONE + `start` → CLEAR: `drv_reset`=1 for one cycle, `drv_out`=`LEDR_0`, `loop_cnt`=0; next strobe 5 cycles after start.
6. Edge and async cases:
   - `start`&`stop` same cycle in RUN → PAUSE.
   - `reset` asserted between clock edges during the effect phase → outputs clear without waiting for clk; `drv_out` returns to `LEDR_0` on the first edge after release.
